// File: rtl/ir_fusion_filt.sv
// Windowed IR wall-centering filter: averages 2^AVG_SHIFT left/right pairs, forms a P+D
// correction and adds it to the desired heading. IR_FUSION_SAT_EN clamps the output instead of wrapping.
module ir_fusion_filt #(
    parameter int              IR_W      = 12,
    parameter int              HDNG_W    = 12,
    parameter logic [IR_W-1:0] NOM_IR    = 12'h970,
    parameter int              AVG_SHIFT = 2,
    parameter int              P_SHIFT   = 5,
    parameter int              D_SHIFT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ir_vld,
    input  logic [IR_W-1:0]          lft_IR,
    input  logic [IR_W-1:0]          rght_IR,
    input  logic                     lft_opn,
    input  logic                     rght_opn,
    input  logic                     en_fusion,
    input  logic signed [HDNG_W-1:0] dsrd_hdng,
    output logic signed [HDNG_W-1:0] dsrd_hdng_adj,
    output logic                     adj_vld,
    output logic                     busy
);

    localparam int ACC_W = IR_W + AVG_SHIFT;
    localparam int CNT_W = AVG_SHIFT + 1;
    localparam int ERR_W = IR_W + 1;
    localparam int D_W   = IR_W + 2;
    localparam int DT_W  = 9 + D_SHIFT;
    localparam int C_W   = HDNG_W + 2;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << AVG_SHIFT) - 1);
    localparam logic signed [8:0] DS_MAX   = 9'h0FF;
    localparam logic signed [8:0] DS_MIN   = 9'h100;

    typedef enum logic [1:0] {IDLE, CALC, DTERM, SUM} state_t;

    state_t                   state;
    logic [ACC_W-1:0]         lft_acc, rght_acc;
    logic [CNT_W-1:0]         cnt;
    logic                     lo_lat, ro_lat, prev_lo, prev_ro, first;
    logic signed [ERR_W-1:0]  err, prev_err;
    logic signed [DT_W-1:0]   dterm;

    logic [IR_W-1:0]          l_avg, r_avg;
    logic signed [ERR_W-1:0]  l_ext, r_ext, nom_ext, err_nxt;
    logic signed [D_W-1:0]    d_raw;
    logic signed [8:0]        d_sat;
    logic signed [DT_W-1:0]   dterm_nxt;
    logic signed [C_W-1:0]    p_ext, corr, hsum;
    logic signed [HDNG_W-1:0] hdng_res;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        l_avg   = lft_acc[ACC_W-1:AVG_SHIFT];
        r_avg   = rght_acc[ACC_W-1:AVG_SHIFT];
        l_ext   = $signed({1'b0, l_avg});
        r_ext   = $signed({1'b0, r_avg});
        nom_ext = $signed({1'b0, NOM_IR});
        err_nxt = '0;
        unique case ({lo_lat, ro_lat})
            2'b11:   err_nxt = '0;
            2'b10:   err_nxt = nom_ext - r_ext;
            2'b01:   err_nxt = l_ext - nom_ext;
            default: err_nxt = (l_ext - r_ext) >>> 1;
        endcase
    end

    // The derivative is meaningless across a wall appearing/vanishing or on the very first window.
    always_comb begin
        d_raw = D_W'(err) - D_W'(prev_err);
        if (first || (lo_lat != prev_lo) || (ro_lat != prev_ro))
            d_raw = '0;
        if (d_raw > D_W'(DS_MAX))
            d_sat = DS_MAX;
        else if (d_raw < D_W'(DS_MIN))
            d_sat = DS_MIN;
        else
            d_sat = 9'(d_raw);
        dterm_nxt = DT_W'(d_sat) <<< D_SHIFT;
    end

    always_comb begin
        p_ext = C_W'(err) >>> P_SHIFT;
        corr  = (p_ext + C_W'(dterm)) >>> 1;
        hsum  = C_W'(dsrd_hdng) + corr;
`ifdef IR_FUSION_SAT_EN
        if (hsum > C_W'($signed({1'b0, {(HDNG_W-1){1'b1}}})))
            hdng_res = {1'b0, {(HDNG_W-1){1'b1}}};
        else if (hsum < C_W'($signed({1'b1, {(HDNG_W-1){1'b0}}})))
            hdng_res = {1'b1, {(HDNG_W-1){1'b0}}};
        else
            hdng_res = HDNG_W'(hsum);
`else
        hdng_res = HDNG_W'(hsum);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lft_acc       <= '0;
            rght_acc      <= '0;
            cnt           <= '0;
            lo_lat        <= 1'b0;
            ro_lat        <= 1'b0;
            prev_lo       <= 1'b0;
            prev_ro       <= 1'b0;
            first         <= 1'b1;
            err           <= '0;
            prev_err      <= '0;
            dterm         <= '0;
            dsrd_hdng_adj <= '0;
            adj_vld       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            adj_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ir_vld) begin
                        lft_acc  <= lft_acc + ACC_W'(lft_IR);
                        rght_acc <= rght_acc + ACC_W'(rght_IR);
                        if (cnt == LAST_CNT) begin
                            lo_lat <= lft_opn;
                            ro_lat <= rght_opn;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    err      <= err_nxt;
                    lft_acc  <= '0;
                    rght_acc <= '0;
                    cnt      <= '0;
                    state    <= DTERM;
                end
                DTERM: begin
                    dterm    <= dterm_nxt;
                    prev_err <= err;
                    prev_lo  <= lo_lat;
                    prev_ro  <= ro_lat;
                    first    <= 1'b0;
                    state    <= SUM;
                end
                SUM: begin
                    dsrd_hdng_adj <= en_fusion ? hdng_res : dsrd_hdng;
                    adj_vld       <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_fusion_filt.sv
// Directed bench for ir_fusion_filt: a reference model pushes expected headings to a
// queue as each window is driven; they are popped and compared when adj_vld pulses.
module tb_ir_fusion_filt;

    logic               clk = 1'b0;
    logic               rst;
    logic               ir_vld;
    logic [11:0]        lft_IR, rght_IR;
    logic               lft_opn, rght_opn;
    logic               en_fusion;
    logic signed [11:0] dsrd_hdng;
    logic signed [11:0] dsrd_hdng_adj;
    logic               adj_vld;
    logic               busy;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];

    int m_prev_err;
    bit m_prev_lo, m_prev_ro, m_first;

    ir_fusion_filt dut (
        .clk          (clk),
        .rst          (rst),
        .ir_vld       (ir_vld),
        .lft_IR       (lft_IR),
        .rght_IR      (rght_IR),
        .lft_opn      (lft_opn),
        .rght_opn     (rght_opn),
        .en_fusion    (en_fusion),
        .dsrd_hdng    (dsrd_hdng),
        .dsrd_hdng_adj(dsrd_hdng_adj),
        .adj_vld      (adj_vld),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_err = 0;
        m_prev_lo  = 1'b0;
        m_prev_ro  = 1'b0;
        m_first    = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst    = 1'b1;
        ir_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int model_err(int l, int r, bit lo, bit ro);
        if (lo && ro) return 0;
        if (lo)       return 'h970 - r;
        if (ro)       return l - 'h970;
        return (l - r) >>> 1;
    endfunction

    // Drives one 4-sample window, predicts its result, then waits (bounded) for adj_vld.
    task automatic run_window(input string tag, input int l_base, input int l_step,
                              input int r_val, input bit lo, input bit ro,
                              input bit en, input int hd, input bit poke_busy);
        int l_sum, e, d, dt, corr, hd_s, hs, res, k;
        logic [11:0] exp_v;
        l_sum = 0;
        for (int i = 0; i < 4; i++) l_sum += l_base + i * l_step;
        e = model_err(l_sum >> 2, r_val, lo, ro);
        d = (m_first || lo != m_prev_lo || ro != m_prev_ro) ? 0 : e - m_prev_err;
        if (d > 255)  d = 255;
        if (d < -256) d = -256;
        dt   = d * 4;
        corr = ((e >>> 5) + dt) >>> 1;
        hd_s = (hd >= 2048) ? hd - 4096 : hd;
        hs   = hd_s + corr;
`ifdef IR_FUSION_SAT_EN
        if (hs > 2047)  hs = 2047;
        if (hs < -2048) hs = -2048;
`endif
        res   = en ? hs : hd_s;
        exp_v = 12'(res);
        m_prev_err = e;
        m_prev_lo  = lo;
        m_prev_ro  = ro;
        m_first    = 1'b0;
        exp_q.push_back(exp_v);

        en_fusion = en;
        dsrd_hdng = 12'(hd);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ir_vld   = 1'b1;
            lft_IR   = 12'(l_base + i * l_step);
            rght_IR  = 12'(r_val);
            lft_opn  = lo;
            rght_opn = ro;
        end
        @(negedge clk);
        ir_vld = 1'b0;
        k = 0;
        while (adj_vld !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({tag, " busy"}, {31'b0, busy}, 32'd1);
                if (poke_busy) begin
                    ir_vld   = 1'b1;
                    lft_IR   = 12'hFFF;
                    rght_IR  = 12'h000;
                    lft_opn  = 1'b1;
                    rght_opn = 1'b0;
                end
            end
            if (k == 2) ir_vld = 1'b0;
        end
        ir_vld = 1'b0;
        check({tag, " latency"}, 32'(k), 32'd3);
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        check({tag, " adj"}, {20'b0, dsrd_hdng_adj}, {20'b0, exp_v});
        @(negedge clk);
        check({tag, " vld_pulse"}, {31'b0, adj_vld}, 32'd0);
        check({tag, " hold"}, {20'b0, dsrd_hdng_adj}, {20'b0, exp_v});
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        ir_vld    = 1'b0;
        lft_IR    = '0;
        rght_IR   = '0;
        lft_opn   = 1'b0;
        rght_opn  = 1'b0;
        en_fusion = 1'b1;
        dsrd_hdng = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset adj",  {20'b0, dsrd_hdng_adj}, 32'h0);
        check("reset vld",  {31'b0, adj_vld}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        // Reset two samples into a window: nothing may come out, next window starts fresh.
        dsrd_hdng = 12'h100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ir_vld  = 1'b1;
            lft_IR  = 12'hC00;
            rght_IR = 12'h400;
        end
        pulse_reset();
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (adj_vld === 1'b1) seen++;
        end
        check("midreset no_vld", 32'(seen), 32'd0);
        check("midreset adj", {20'b0, dsrd_hdng_adj}, 32'h0);

        run_window("avg", 'hA00, 4, 'h900, 1'b0, 1'b0, 1'b1, 'h100, 1'b0);
        check("avg literal", {20'b0, dsrd_hdng_adj}, 32'h102);

        run_window("d_pre", 'hA00, 0, 'h900, 1'b0, 1'b0, 1'b1, 'h100, 1'b0);
        run_window("d_term", 'hA40, 0, 'h900, 1'b0, 1'b0, 1'b1, 'h100, 1'b0);
        check("d_term literal", {20'b0, dsrd_hdng_adj}, 32'h142);

        run_window("ropen", 'h9F0, 0, 'h900, 1'b0, 1'b1, 1'b1, 'h100, 1'b0);
        check("ropen literal", {20'b0, dsrd_hdng_adj}, 32'h102);
        run_window("both_open", 'h9F0, 0, 'h900, 1'b1, 1'b1, 1'b1, 'h100, 1'b0);
        check("both_open literal", {20'b0, dsrd_hdng_adj}, 32'h100);

        run_window("zero_err", 'h900, 0, 'h900, 1'b0, 1'b0, 1'b1, 'h100, 1'b0);
        run_window("d_sat", 'hFFF, 0, 'h000, 1'b0, 1'b0, 1'b1, 'h100, 1'b0);
        check("d_sat literal", {20'b0, dsrd_hdng_adj}, 32'h31D);
        run_window("zero_err2", 'h900, 0, 'h900, 1'b0, 1'b0, 1'b1, 'h100, 1'b0);
        run_window("en_off", 'hFFF, 0, 'h000, 1'b0, 1'b0, 1'b0, 'h100, 1'b0);
        check("en_off literal", {20'b0, dsrd_hdng_adj}, 32'h100);

        pulse_reset();
        run_window("ovf", 'hFFF, 0, 'h000, 1'b0, 1'b0, 1'b1, 'h7F0, 1'b1);
`ifdef IR_FUSION_SAT_EN
        check("ovf literal", {20'b0, dsrd_hdng_adj}, 32'h7FF);
`else
        check("ovf literal", {20'b0, dsrd_hdng_adj}, 32'h80F);
`endif
        run_window("post_drop", 'h900, 0, 'h900, 1'b0, 1'b0, 1'b1, 'h7F0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
